// File: rtl/demux_4way.sv
// 1-to-4 single-bit demultiplexer with a registered copy of each output
// and a saturating per-channel activity counter for debug visibility.
module demux_4way #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       select,
    input  logic             in,
    output logic             outA,
    output logic             outB,
    output logic             outC,
    output logic             outD,
    output logic             outA_q,
    output logic             outB_q,
    output logic             outC_q,
    output logic             outD_q,
    output logic [CNT_W-1:0] cntA,
    output logic [CNT_W-1:0] cntB,
    output logic [CNT_W-1:0] cntC,
    output logic [CNT_W-1:0] cntD
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Counter step that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] value);
        if (value == CNT_MAX) begin
            return value;
        end else begin
            return value + CNT_ONE;
        end
    endfunction

    // Combinational steering of in onto the selected channel; others driven low.
    always_comb begin
        outA = 1'b0;
        outB = 1'b0;
        outC = 1'b0;
        outD = 1'b0;
        case (select)
            2'b00:   outA = in;
            2'b01:   outB = in;
            2'b10:   outC = in;
            2'b11:   outD = in;
            default: begin
                outA = 1'b0;
                outB = 1'b0;
                outC = 1'b0;
                outD = 1'b0;
            end
        endcase
    end

    // Registered copy of the demux outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            outA_q <= 1'b0;
            outB_q <= 1'b0;
            outC_q <= 1'b0;
            outD_q <= 1'b0;
        end else begin
            outA_q <= outA;
            outB_q <= outB;
            outC_q <= outC;
            outD_q <= outD;
        end
    end

    // Activity counters: a channel counts only when it actually carried a 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cntA <= {CNT_W{1'b0}};
            cntB <= {CNT_W{1'b0}};
            cntC <= {CNT_W{1'b0}};
            cntD <= {CNT_W{1'b0}};
        end else begin
            if (outA) cntA <= satInc(cntA);
            else      cntA <= cntA;
            if (outB) cntB <= satInc(cntB);
            else      cntB <= cntB;
            if (outC) cntC <= satInc(cntC);
            else      cntC <= cntC;
            if (outD) cntD <= satInc(cntD);
            else      cntD <= cntD;
        end
    end

endmodule

// File: tb/tb_demux_4way.sv
// Scoreboard bench for demux_4way: default-width and 4-bit-counter instances
// driven in parallel from the same stimulus.
module tb_demux_4way;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] select;
    logic       in;

    logic [3:0] comb8, comb4, q8, q4;
    logic [7:0] cnt8 [4];
    logic [3:0] cnt4 [4];

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0]      q;
        logic [3:0][7:0] c8;
        logic [3:0][3:0] c4;
    } exp_t;

    exp_t sb[$];
    exp_t model;

    demux_4way #(.CNT_W(8)) dut8 (
        .clk(clk), .reset(reset), .select(select), .in(in),
        .outA(comb8[0]), .outB(comb8[1]), .outC(comb8[2]), .outD(comb8[3]),
        .outA_q(q8[0]), .outB_q(q8[1]), .outC_q(q8[2]), .outD_q(q8[3]),
        .cntA(cnt8[0]), .cntB(cnt8[1]), .cntC(cnt8[2]), .cntD(cnt8[3])
    );

    demux_4way #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .select(select), .in(in),
        .outA(comb4[0]), .outB(comb4[1]), .outC(comb4[2]), .outD(comb4[3]),
        .outA_q(q4[0]), .outB_q(q4[1]), .outC_q(q4[2]), .outD_q(q4[3]),
        .cntA(cnt4[0]), .cntB(cnt4[1]), .cntC(cnt4[2]), .cntD(cnt4[3])
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] oneHot(input logic [1:0] s, input logic i);
        logic [3:0] r;
        r = 4'b0000;
        if (i) r[s] = 1'b1;
        return r;
    endfunction

    task automatic checkComb(input string tag);
        checkVal({tag, "_comb8"}, 32'(comb8), 32'(oneHot(select, in)));
        checkVal({tag, "_comb4"}, 32'(comb4), 32'(oneHot(select, in)));
    endtask

    task automatic checkRegs(input string tag, input exp_t e);
        checkVal({tag, "_q8"}, 32'(q8), 32'(e.q));
        checkVal({tag, "_q4"}, 32'(q4), 32'(e.q));
        for (int k = 0; k < 4; k++) begin
            checkVal($sformatf("%s_cnt8_%0d", tag, k), 32'(cnt8[k]), 32'(e.c8[k]));
            checkVal($sformatf("%s_cnt4_%0d", tag, k), 32'(cnt4[k]), 32'(e.c4[k]));
        end
    endtask

    // Drive one cycle of stimulus just after a falling edge, predict, then check.
    task automatic step(input logic [1:0] s, input logic i);
        exp_t e;
        select = s;
        in     = i;
        #1;
        checkComb("step");
        model.q = oneHot(s, i);
        if (i) begin
            if (model.c8[s] != 8'hFF) model.c8[s] = model.c8[s] + 8'd1;
            if (model.c4[s] != 4'hF)  model.c4[s] = model.c4[s] + 4'd1;
        end
        sb.push_back(model);
        @(posedge clk);
        @(negedge clk);
        e = sb.pop_front();
        checkRegs("step", e);
    endtask

    // Assert reset between edges and confirm it clears immediately and holds.
    task automatic asyncReset();
        #2;
        reset = 1'b1;
        #1;
        model = '0;
        sb.delete();
        checkRegs("rst_now", model);
        select = 2'b01;
        in     = 1'b1;
        #1;
        checkComb("rst_comb");
        select = 2'b10;
        #1;
        checkComb("rst_comb2");
        @(posedge clk);
        @(negedge clk);
        checkRegs("rst_hold", model);
        reset  = 1'b0;
        in     = 1'b0;
    endtask

    initial begin
        reset  = 1'b1;
        select = 2'b00;
        in     = 1'b0;
        model  = '0;
        @(negedge clk);
        checkRegs("reset", model);
        reset = 1'b0;

        for (int s = 0; s < 4; s++) step(2'(s), 1'b0);
        for (int s = 0; s < 4; s++) step(2'(s), 1'b1);

        step(2'b10, 1'b1);
        checkVal("regC_one", 32'(q8), 32'h4);
        step(2'b10, 1'b0);
        checkVal("regC_zero", 32'(q8), 32'h0);

        asyncReset();

        for (int n = 0; n < 5; n++) step(2'b01, 1'b1);
        for (int n = 0; n < 3; n++) step(2'b01, 1'b0);
        checkVal("cntB_5", 32'(cnt8[1]), 32'd5);
        checkVal("cntA_0", 32'(cnt8[0]), 32'd0);

        for (int n = 0; n < 20; n++) step(2'b11, 1'b1);
        checkVal("cntD_sat4", 32'(cnt4[3]), 32'd15);
        checkVal("cntD_20", 32'(cnt8[3]), 32'd20);
        step(2'b11, 1'b1);
        checkVal("cntD_hold4", 32'(cnt4[3]), 32'd15);

        asyncReset();
        step(2'b00, 1'b1);
        checkVal("post_rst_cntA", 32'(cnt8[0]), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
